// File: rtl/lru_pkg.sv
// Shared types and helpers for the 4-way true-LRU replacement controller.
package lru_pkg;

  localparam int WAYS = 4;

  typedef logic [1:0] age_t;
  typedef logic [1:0] way_t;
  typedef age_t [WAYS-1:0] set_age_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHOOSE = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  typedef enum logic {
    OP_TOUCH = 1'b0,
    OP_INVAL = 1'b1
  } age_op_t;

  // Way holding age 3 (the least recently used way of the set).
  function automatic way_t lru_of(set_age_t ages);
    way_t v;
    v = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (ages[i] == 2'd3) v = way_t'(i);
    end
    return v;
  endfunction

  // Lowest-index invalid way wins; with all ways valid, fall back to the LRU way.
  function automatic way_t victim_of(set_age_t ages, logic [3:0] vmask);
    way_t v;
    v = lru_of(ages);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vmask[i]) v = way_t'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/lru4_age_update.sv
// Combinational next-age computation for one set: touch (make MRU) or invalidate (make LRU).
module lru4_age_update
  import lru_pkg::*;
(
  input  set_age_t ages_in,
  input  way_t     way,
  input  age_op_t  op,
  output set_age_t ages_out
);

  age_t ref_age;

  // Shift the ages around the reference way so the set stays a permutation of 0..3.
  always_comb begin
    ref_age  = ages_in[way];
    ages_out = ages_in;
    for (int i = 0; i < WAYS; i++) begin
      if (op == OP_TOUCH) begin
        if (way_t'(i) == way)         ages_out[i] = 2'd0;
        else if (ages_in[i] < ref_age) ages_out[i] = ages_in[i] + 2'd1;
      end else begin
        if (way_t'(i) == way)         ages_out[i] = 2'd3;
        else if (ages_in[i] > ref_age) ages_out[i] = ages_in[i] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/lru_replacement_ctrl.sv
// Per-set 4-way true-LRU replacement controller: owns the age array, arbitrates the single
// age write port between invalidate, hit-touch and allocation commit, and picks victims.
//
// Handshakes: a hit is transferred in a cycle where hit_valid && hit_ready; while hit_ready
// is low the requester holds hit_set/hit_way stable. An allocation is accepted in a cycle
// where alloc_req && alloc_ready; alloc_set/alloc_vmask are sampled only then. Invalidates
// have no ready and are always taken.
module lru_replacement_ctrl
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inv_valid,
  input  logic [SET_W-1:0] inv_set,
  input  logic [1:0]       inv_way,
  input  logic             hit_valid,
  input  logic [SET_W-1:0] hit_set,
  input  logic [1:0]       hit_way,
  output logic             hit_ready,
  input  logic             alloc_req,
  input  logic [SET_W-1:0] alloc_set,
  input  logic [3:0]       alloc_vmask,
  output logic             alloc_ready,
  output logic             alloc_done,
  output logic [1:0]       alloc_way,
  input  logic [SET_W-1:0] peek_set,
  output logic [1:0]       peek_lru,
  output alloc_state_t     alloc_state
);

  set_age_t         ages [NUM_SETS];
  alloc_state_t     state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [3:0]       vmask_q;
  way_t             victim_q;

  logic             hit_fire;
  logic             ext_wr;
  logic [SET_W-1:0] ext_set;
  logic             ext_same;
  logic             wr_en;
  logic [SET_W-1:0] wr_set;
  way_t             wr_way;
  age_op_t          wr_op;
  set_age_t         wr_next;

  assign hit_ready   = !inv_valid;
  assign hit_fire    = hit_valid && hit_ready;
  assign ext_wr      = inv_valid || hit_fire;
  assign ext_set     = inv_valid ? inv_set : hit_set;
  assign ext_same    = ext_wr && (ext_set == set_q);
  assign alloc_ready = (state_q == IDLE);
  assign alloc_way   = alloc_done ? victim_q : 2'd0;
  assign peek_lru    = lru_of(ages[peek_set]);
  assign alloc_state = state_q;

  // Write-port arbitration: invalidate beats hit, hit beats the allocation commit.
  always_comb begin
    wr_en  = 1'b0;
    wr_set = inv_set;
    wr_way = inv_way;
    wr_op  = OP_INVAL;
    if (inv_valid) begin
      wr_en = 1'b1;
    end else if (hit_valid) begin
      wr_en  = 1'b1;
      wr_set = hit_set;
      wr_way = hit_way;
      wr_op  = OP_TOUCH;
    end else if (state_q == COMMIT) begin
      wr_en  = 1'b1;
      wr_set = set_q;
      wr_way = victim_q;
      wr_op  = OP_TOUCH;
    end
  end

  lru4_age_update u_age_update (
    .ages_in  (ages[wr_set]),
    .way      (wr_way),
    .op       (wr_op),
    .ages_out (wr_next)
  );

  // Age array: identity order on reset, one set rewritten per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ages[s][w] <= age_t'(w);
        end
      end
    end else if (wr_en) begin
      ages[wr_set] <= wr_next;
    end
  end

  // Allocation FSM next state; a same-set external write forces the victim to be re-chosen.
  always_comb begin
    state_d    = state_q;
    alloc_done = 1'b0;
    case (state_q)
      IDLE:   if (alloc_req) state_d = CHOOSE;
      CHOOSE: if (!ext_same) state_d = COMMIT;
      COMMIT: begin
        if (!ext_wr) begin
          alloc_done = 1'b1;
          state_d    = IDLE;
        end else if (ext_same) begin
          state_d = CHOOSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Allocation FSM registers: request capture in IDLE, victim capture in CHOOSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      set_q    <= '0;
      vmask_q  <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && alloc_req) begin
        set_q   <= alloc_set;
        vmask_q <= alloc_vmask;
      end
      if (state_q == CHOOSE) begin
        victim_q <= victim_of(ages[set_q], vmask_q);
      end
    end
  end

endmodule

// File: tb/tb_lru_replacement_ctrl.sv
// Directed bench for lru_replacement_ctrl with hand-computed ages and victims.
module tb_lru_replacement_ctrl;
  import lru_pkg::*;

  localparam int NUM_SETS = 16;
  localparam int SET_W    = 4;

  logic             clk;
  logic             rst_n;
  logic             inv_valid;
  logic [SET_W-1:0] inv_set;
  logic [1:0]       inv_way;
  logic             hit_valid;
  logic [SET_W-1:0] hit_set;
  logic [1:0]       hit_way;
  logic             hit_ready;
  logic             alloc_req;
  logic [SET_W-1:0] alloc_set;
  logic [3:0]       alloc_vmask;
  logic             alloc_ready;
  logic             alloc_done;
  logic [1:0]       alloc_way;
  logic [SET_W-1:0] peek_set;
  logic [1:0]       peek_lru;
  alloc_state_t     alloc_state;

  int n_vec;
  int n_err;

  lru_replacement_ctrl #(.NUM_SETS(NUM_SETS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inv_valid   (inv_valid),
    .inv_set     (inv_set),
    .inv_way     (inv_way),
    .hit_valid   (hit_valid),
    .hit_set     (hit_set),
    .hit_way     (hit_way),
    .hit_ready   (hit_ready),
    .alloc_req   (alloc_req),
    .alloc_set   (alloc_set),
    .alloc_vmask (alloc_vmask),
    .alloc_ready (alloc_ready),
    .alloc_done  (alloc_done),
    .alloc_way   (alloc_way),
    .peek_set    (peek_set),
    .peek_lru    (peek_lru),
    .alloc_state (alloc_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inv_valid   = 1'b0;
    inv_set     = '0;
    inv_way     = '0;
    hit_valid   = 1'b0;
    hit_set     = '0;
    hit_way     = '0;
    alloc_req   = 1'b0;
    alloc_set   = '0;
    alloc_vmask = '0;
    peek_set    = '0;
  endtask

  task automatic start_alloc(input logic [SET_W-1:0] s, input logic [3:0] vm);
    alloc_req   = 1'b1;
    alloc_set   = s;
    alloc_vmask = vm;
    tick();
    alloc_req   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
    n_vec++;
    if (hit_ready !== 1'b1) begin n_err++; $display("FAIL reset_hit_ready got=%b exp=1", hit_ready); end
    n_vec++;
    if (alloc_done !== 1'b0 || alloc_way !== 2'd0) begin
      n_err++; $display("FAIL reset_done got=%b/%0d exp=0/0", alloc_done, alloc_way);
    end
    n_vec++;
    if (alloc_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", alloc_state, IDLE); end
    for (int s = 0; s < NUM_SETS; s++) begin
      peek_set = SET_W'(s);
      #1;
      n_vec++;
      if (peek_lru !== 2'd3) begin n_err++; $display("FAIL reset_peek set=%0d got=%0d exp=3", s, peek_lru); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alloc_full();
    start_alloc(4'd5, 4'b1111);
    n_vec++;
    if (alloc_state !== CHOOSE || alloc_done !== 1'b0) begin
      n_err++; $display("FAIL alloc5_choose state=%0d done=%b exp=%0d/0", alloc_state, alloc_done, CHOOSE);
    end
    n_vec++;
    if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL alloc5_busy_ready got=%b exp=0", alloc_ready); end
    tick();
    n_vec++;
    if (alloc_done !== 1'b1 || alloc_way !== 2'd3) begin
      n_err++; $display("FAIL alloc5_done got=%b/%0d exp=1/3", alloc_done, alloc_way);
    end
    tick();
    n_vec++;
    if (alloc_done !== 1'b0 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL alloc5_pulse done=%b ready=%b exp=0/1", alloc_done, alloc_ready);
    end
    peek_set = 4'd5;
    #1;
    n_vec++;
    if (peek_lru !== 2'd2) begin n_err++; $display("FAIL alloc5_peek got=%0d exp=2", peek_lru); end
  endtask

  task automatic test_hit_sequence();
    logic [1:0] ways [4];
    ways = '{2'd2, 2'd0, 2'd3, 2'd1};
    hit_valid = 1'b1;
    hit_set   = 4'd2;
    for (int i = 0; i < 4; i++) begin
      hit_way = ways[i];
      #1;
      n_vec++;
      if (hit_ready !== 1'b1) begin n_err++; $display("FAIL hit_ready idx=%0d got=%b exp=1", i, hit_ready); end
      tick();
    end
    hit_valid = 1'b0;
    peek_set = 4'd2;
    #1;
    n_vec++;
    if (peek_lru !== 2'd2) begin n_err++; $display("FAIL hit_peek2 got=%0d exp=2", peek_lru); end
    peek_set = 4'd0;
    #1;
    n_vec++;
    if (peek_lru !== 2'd3) begin n_err++; $display("FAIL hit_peek0 got=%0d exp=3", peek_lru); end
    peek_set = 4'd3;
    #1;
    n_vec++;
    if (peek_lru !== 2'd3) begin n_err++; $display("FAIL hit_peek3 got=%0d exp=3", peek_lru); end
  endtask

  task automatic test_alloc_invalid_way();
    start_alloc(4'd9, 4'b1011);
    tick();
    n_vec++;
    if (alloc_done !== 1'b1 || alloc_way !== 2'd2) begin
      n_err++; $display("FAIL alloc9_done got=%b/%0d exp=1/2", alloc_done, alloc_way);
    end
    tick();
    peek_set = 4'd9;
    #1;
    n_vec++;
    if (peek_lru !== 2'd3) begin n_err++; $display("FAIL alloc9_peek got=%0d exp=3", peek_lru); end
  endtask

  task automatic test_choose_conflict();
    start_alloc(4'd7, 4'b1111);
    hit_valid = 1'b1;
    hit_set   = 4'd7;
    hit_way   = 2'd3;
    tick();
    hit_valid = 1'b0;
    n_vec++;
    if (alloc_state !== CHOOSE || alloc_done !== 1'b0) begin
      n_err++; $display("FAIL alloc7_restay state=%0d done=%b exp=%0d/0", alloc_state, alloc_done, CHOOSE);
    end
    tick();
    n_vec++;
    if (alloc_done !== 1'b1 || alloc_way !== 2'd2) begin
      n_err++; $display("FAIL alloc7_done got=%b/%0d exp=1/2", alloc_done, alloc_way);
    end
    tick();
    peek_set = 4'd7;
    #1;
    n_vec++;
    if (peek_lru !== 2'd1) begin n_err++; $display("FAIL alloc7_peek got=%0d exp=1", peek_lru); end
  endtask

  task automatic test_commit_stall();
    start_alloc(4'd10, 4'b1111);
    tick();
    hit_valid = 1'b1;
    hit_set   = 4'd11;
    hit_way   = 2'd0;
    #1;
    n_vec++;
    if (alloc_done !== 1'b0 || alloc_state !== COMMIT) begin
      n_err++; $display("FAIL commit_stall done=%b state=%0d exp=0/%0d", alloc_done, alloc_state, COMMIT);
    end
    tick();
    hit_valid = 1'b0;
    #1;
    n_vec++;
    if (alloc_done !== 1'b1 || alloc_way !== 2'd3) begin
      n_err++; $display("FAIL commit_resume got=%b/%0d exp=1/3", alloc_done, alloc_way);
    end
    tick();
    peek_set = 4'd11;
    #1;
    n_vec++;
    if (peek_lru !== 2'd3) begin n_err++; $display("FAIL commit_peek11 got=%0d exp=3", peek_lru); end
    peek_set = 4'd10;
    #1;
    n_vec++;
    if (peek_lru !== 2'd2) begin n_err++; $display("FAIL commit_peek10 got=%0d exp=2", peek_lru); end
  endtask

  task automatic test_inv_hit_same_set();
    inv_valid = 1'b1;
    inv_set   = 4'd1;
    inv_way   = 2'd0;
    hit_valid = 1'b1;
    hit_set   = 4'd1;
    hit_way   = 2'd2;
    peek_set  = 4'd1;
    #1;
    n_vec++;
    if (hit_ready !== 1'b0) begin n_err++; $display("FAIL inv_hit_ready got=%b exp=0", hit_ready); end
    tick();
    inv_valid = 1'b0;
    #1;
    n_vec++;
    if (peek_lru !== 2'd0) begin n_err++; $display("FAIL inv_peek got=%0d exp=0", peek_lru); end
    n_vec++;
    if (hit_ready !== 1'b1) begin n_err++; $display("FAIL held_hit_ready got=%b exp=1", hit_ready); end
    tick();
    hit_valid = 1'b0;
    #1;
    n_vec++;
    if (peek_lru !== 2'd0) begin n_err++; $display("FAIL held_hit_peek got=%0d exp=0", peek_lru); end
  endtask

  task automatic test_reset_mid_alloc();
    start_alloc(4'd3, 4'b1111);
    n_vec++;
    if (alloc_state !== CHOOSE) begin n_err++; $display("FAIL midrst_pre state=%0d exp=%0d", alloc_state, CHOOSE); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (alloc_ready !== 1'b1 || alloc_state !== IDLE) begin
      n_err++; $display("FAIL midrst_ready ready=%b state=%0d exp=1/%0d", alloc_ready, alloc_state, IDLE);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (alloc_done !== 1'b0) begin n_err++; $display("FAIL midrst_nodone cyc=%0d got=%b exp=0", c, alloc_done); end
    end
    for (int s = 0; s < NUM_SETS; s++) begin
      peek_set = SET_W'(s);
      #1;
      n_vec++;
      if (peek_lru !== 2'd3) begin n_err++; $display("FAIL midrst_peek set=%0d got=%0d exp=3", s, peek_lru); end
    end
  endtask

  // Test sequence and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc_full();
    test_hit_sequence();
    test_alloc_invalid_way();
    test_choose_conflict();
    test_commit_stall();
    test_inv_hit_same_set();
    test_reset_mid_alloc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
